instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 The block SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, meaning the asynchronous active-low reset.
REQ-004 The block SHALL have port imem_req, output, 1, meaning an instruction memory read request.
REQ-005 The block SHALL have port imem_addr, output, 32, meaning the byte address of the request.
REQ-006 The block SHALL have port imem_ack, input, 1, meaning the memory returns imem_rdata this cycle.
REQ-007 The block SHALL have port imem_rdata, input, 32, meaning the instruction word, valid only while imem_ack=1.
REQ-008 The block SHALL have port instr, output, 32, meaning the registered instruction word driven to the interpreter.
REQ-009 The block SHALL have port instr_valid, output, 1, meaning instr holds a live instruction.
REQ-010 The block SHALL have port instr_ready, input, 1, meaning the downstream stage consumes instr this cycle.
REQ-011 The block SHALL have port instr_pc, output, 32, meaning the address instr was fetched from.
REQ-012 The block SHALL have port jump_en, input, 1, meaning a one-cycle redirect request.
REQ-013 The block SHALL have port jump_target, input, 32, meaning the redirect byte address.
REQ-014 The block SHALL have port halted, output, 1, meaning a halt word (opcode 0) was fetched and fetching has stopped.

Function
REQ-015 The block SHALL use a three-state FSM: FETCH, HOLD and HALT; it SHALL also keep a stale flag and the pc register.
REQ-016 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc, and both SHALL hold stable until the cycle imem_ack=1.
REQ-017 On imem_ack in FETCH with stale=0, the block SHALL load instr<=imem_rdata, instr_pc<=pc and pc<=pc+4, set instr_valid=1 and move to HOLD, so instr_valid rises exactly one cycle after imem_ack.
REQ-018 The pc increment SHALL be modulo 2^32, so 32'hFFFF_FFFC+4 yields 32'h0000_0000.
REQ-019 In HOLD, imem_req SHALL be 0; when instr_ready=1, instr_valid SHALL clear next cycle and the FSM SHALL go to FETCH, unless the held opcode instr[31:26]==0, in which case the FSM SHALL go to HALT.
REQ-020 In HOLD with instr_ready=0, instr, instr_pc and instr_valid SHALL remain unchanged.
REQ-021 In HALT, imem_req=0, instr_valid=0 and halted=1; the block SHALL stay in HALT until jump_en or reset.
REQ-022 On jump_en in any state, pc SHALL load {jump_target[31:2],2'b00}; the low two bits SHALL always be forced to 0.
REQ-023 A jump in HOLD SHALL discard the held instruction (instr_valid=0 next cycle, even if instr_ready=1 in the same cycle) and enter FETCH.
REQ-024 A jump in HALT SHALL clear halted and enter FETCH.
REQ-025 A jump in FETCH without imem_ack SHALL keep imem_req/imem_addr unchanged until ack (no request withdrawal) and set stale=1.
REQ-026 An ack with stale=1 SHALL drop the data, clear stale, keep instr_valid=0 and reissue the request from the new pc next cycle.
REQ-027 A jump in FETCH coincident with imem_ack SHALL drop the returned data and fetch from the target next cycle.
REQ-028 imem_ack outside FETCH SHALL be ignored.

Reset
REQ-029 Asserting rst_n=0 SHALL immediately force: state=FETCH, pc=RESET_PC, stale=0, instr=0, instr_pc=0, instr_valid=0, halted=0 and imem_req=0.
REQ-030 After rst_n deasserts, imem_req SHALL assert on the first rising edge; an outstanding request cut by reset mid-operation SHALL be forgotten, and the memory SHALL be reset in the same domain.

Structure
REQ-031 The shared package cpu_pkg SHALL hold OPCODE_MSB/LSB (31/26), HALT_OPCODE=6'b000000, PC_STEP=4 and the fetch state enum.
REQ-032 The pc register with its increment/jump load SHALL be a sub-module named pc_reg; the FSM, stale flag and output registers SHALL remain in instruction_fetch.

Verification
REQ-033 The bench SHALL cover: reset, then a 1-cycle-ack memory returning 0x04000000 at address 0 -> instr_valid=1 one cycle after ack, instr_pc=0, next imem_addr=4.
REQ-034 The bench SHALL cover: instr_ready held 0 for 5 cycles -> instr stable, imem_req=0 throughout.
REQ-035 The bench SHALL cover: jump_en with target 0x103 issued during a 3-cycle-latency fetch -> the stale word is dropped and the next imem_addr=0x100.
REQ-036 The bench SHALL cover: fetching 0x00000000 -> it is presented once and consumed, then halted=1 and imem_req stays 0; a jump to 0x40 -> resume at 0x40.
REQ-037 The bench SHALL cover: pc=0xFFFFFFFC acked -> next imem_addr=0x00000000.
REQ-038 The bench SHALL cover: rst_n pulsed low while in HOLD -> outputs cleared asynchronously, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: opcode field position, halt encoding,
// pc step and the fetch FSM state type.
package cpu_pkg;

  localparam int          OPCODE_MSB  = 31;
  localparam int          OPCODE_LSB  = 26;
  localparam logic [5:0]  HALT_OPCODE = 6'b000000;
  localparam logic [31:0] PC_STEP     = 32'd4;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter: word-aligned jump load has priority over the sequential
// increment; the increment wraps naturally at 2^32.
module pc_reg
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_jump_en,
  input  logic [31:0] i_jump_target,
  input  logic        i_inc_en,
  output logic [31:0] o_pc
);

  logic [31:0] r_pc;
  logic [31:0] w_target_aligned;

  assign w_target_aligned = i_jump_target & ~32'h0000_0003;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (i_jump_en) begin
      r_pc <= w_target_aligned;
    end else if (i_inc_en) begin
      r_pc <= r_pc + PC_STEP;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: issues one memory read at a time, holds the
// returned word until the interpreter consumes it, and stops on a halt word.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_pc,
  input  logic        jump_en,
  input  logic [31:0] jump_target,
  output logic        halted
);

  fetch_state_t r_state;
  fetch_state_t w_state_next;

  logic        r_started;
  logic        r_stale;
  logic [31:0] r_req_addr;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;

  logic [31:0] w_pc;
  logic        w_req;
  logic        w_accept;
  logic        w_held_halt;

  // Requests stay off until the first edge after reset so a request cut
  // by reset is never mistaken for a live one.
  assign w_req       = (r_state == ST_FETCH) && r_started;
  assign w_accept    = w_req && imem_ack && !r_stale && !jump_en;
  assign w_held_halt = (r_instr[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE);

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_jump_en     (jump_en),
    .i_jump_target (jump_target),
    .i_inc_en      (w_accept),
    .o_pc          (w_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    imem_req     = w_req;
    imem_addr    = w_pc;
    instr_valid  = 1'b0;
    halted       = 1'b0;
    if (r_stale) begin
      imem_addr = r_req_addr;
    end
    case (r_state)
      ST_FETCH: begin
        if (w_accept) begin
          w_state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        instr_valid = 1'b1;
        if (jump_en) begin
          w_state_next = ST_FETCH;
        end else if (instr_ready) begin
          w_state_next = w_held_halt ? ST_HALT : ST_FETCH;
        end
      end
      ST_HALT: begin
        halted = 1'b1;
        if (jump_en) begin
          w_state_next = ST_FETCH;
        end
      end
      default: begin
        w_state_next = ST_FETCH;
      end
    endcase
  end

  // A redirect during an outstanding read keeps the old address on the bus
  // until the ack, then that data is thrown away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_started  <= 1'b0;
      r_stale    <= 1'b0;
      r_req_addr <= 32'h0000_0000;
      r_instr    <= 32'h0000_0000;
      r_instr_pc <= 32'h0000_0000;
    end else begin
      r_started <= 1'b1;
      if (!r_stale) begin
        r_req_addr <= w_pc;
      end
      if (w_req) begin
        if (imem_ack) begin
          r_stale <= 1'b0;
        end else if (jump_en) begin
          r_stale <= 1'b1;
        end
      end
      if (w_accept) begin
        r_instr    <= imem_rdata;
        r_instr_pc <= w_pc;
      end
    end
  end

  assign instr    = r_instr;
  assign instr_pc = r_instr_pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: scripted memory responses with a
// scoreboard of expected {pc, word} pairs popped when instr_valid appears.
module tb_instruction_fetch;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_pc;
  logic        jump_en;
  logic [31:0] jump_target;
  logic        halted;

  int n_checks;
  int n_errors;
  logic [63:0] sb_q[$];

  instruction_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_pc    (instr_pc),
    .jump_en     (jump_en),
    .jump_target (jump_target),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end else begin
      $display("ok   %s: %b", name, act);
    end
  endtask

  // Serve one read: wait for the request, hold it lat cycles, ack, then
  // compare the presented instruction against the scoreboard.
  task automatic fetch_word(input string name, input logic [31:0] exp_addr,
                            input logic [31:0] data, input int lat);
    logic [63:0] exp;
    int n;
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check1({name, "_req"}, imem_req, 1'b1);
    if (imem_req !== 1'b1) return;
    check32({name, "_addr"}, imem_addr, exp_addr);
    for (int i = 1; i < lat; i++) begin
      tick();
      check1({name, "_req_hold"}, imem_req, 1'b1);
      check32({name, "_addr_hold"}, imem_addr, exp_addr);
    end
    imem_ack   = 1'b1;
    imem_rdata = data;
    sb_q.push_back({exp_addr, data});
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    exp = sb_q.pop_front();
    check1({name, "_valid"}, instr_valid, 1'b1);
    check32({name, "_instr"}, instr, exp[31:0]);
    check32({name, "_pc"}, instr_pc, exp[63:32]);
  endtask

  task automatic consume(input string name);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check1({name, "_consumed"}, instr_valid, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    check1("rst_req", imem_req, 1'b0);
    check1("rst_valid", instr_valid, 1'b0);
    check1("rst_halted", halted, 1'b0);
    check32("rst_instr", instr, 32'h0);
    check32("rst_pc", instr_pc, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check1("rst_release_req", imem_req, 1'b0);
    tick();
    check1("first_edge_req", imem_req, 1'b1);
    check32("first_edge_addr", imem_addr, 32'h0);
  endtask

  task automatic test_basic();
    fetch_word("basic", 32'h0, 32'h0400_0000, 1);
  endtask

  task automatic test_stall();
    for (int i = 0; i < 5; i++) begin
      tick();
      check1("stall_req", imem_req, 1'b0);
      check1("stall_valid", instr_valid, 1'b1);
      check32("stall_instr", instr, 32'h0400_0000);
      check32("stall_pc", instr_pc, 32'h0);
    end
    consume("stall");
    check32("next_addr", imem_addr, 32'h4);
  endtask

  task automatic test_jump_stale();
    int n;
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check32("stale_addr0", imem_addr, 32'h4);
    jump_en     = 1'b1;
    jump_target = 32'h0000_0103;
    tick();
    jump_en = 1'b0;
    check1("stale_req_kept", imem_req, 1'b1);
    check32("stale_addr_kept", imem_addr, 32'h4);
    tick();
    check32("stale_addr_kept2", imem_addr, 32'h4);
    imem_ack   = 1'b1;
    imem_rdata = 32'h0800_0000;
    tick();
    imem_ack = 1'b0;
    check1("stale_dropped", instr_valid, 1'b0);
    check32("stale_new_addr", imem_addr, 32'h100);
    fetch_word("after_jump", 32'h100, 32'h0C00_0000, 1);
    consume("after_jump");
  endtask

  task automatic test_halt();
    fetch_word("halt_word", 32'h104, 32'h0000_0000, 2);
    consume("halt_word");
    for (int i = 0; i < 4; i++) begin
      check1("halt_flag", halted, 1'b1);
      check1("halt_req", imem_req, 1'b0);
      imem_ack = 1'b1;
      tick();
      imem_ack = 1'b0;
    end
    check1("halt_ack_ignored", instr_valid, 1'b0);
    jump_en     = 1'b1;
    jump_target = 32'h40;
    tick();
    jump_en = 1'b0;
    check1("resume_halted", halted, 1'b0);
    fetch_word("resume", 32'h40, 32'h1000_0000, 1);
    consume("resume");
  endtask

  task automatic test_wrap();
    fetch_word("pre_wrap", 32'h44, 32'h1400_0000, 1);
    jump_en     = 1'b1;
    jump_target = 32'hFFFF_FFFD;
    instr_ready = 1'b1;
    tick();
    jump_en     = 1'b0;
    instr_ready = 1'b0;
    check1("hold_jump_discard", instr_valid, 1'b0);
    fetch_word("wrap", 32'hFFFF_FFFC, 32'h1800_0000, 1);
    consume("wrap");
    check32("wrap_addr", imem_addr, 32'h0);
    imem_ack    = 1'b1;
    imem_rdata  = 32'h2000_0000;
    jump_en     = 1'b1;
    jump_target = 32'h200;
    tick();
    imem_ack = 1'b0;
    jump_en  = 1'b0;
    check1("ack_jump_drop", instr_valid, 1'b0);
    check32("ack_jump_addr", imem_addr, 32'h200);
    fetch_word("ack_jump", 32'h200, 32'h2400_0000, 3);
  endtask

  task automatic test_reset_in_hold();
    #2;
    rst_n = 1'b0;
    #1;
    check1("hold_rst_valid", instr_valid, 1'b0);
    check1("hold_rst_req", imem_req, 1'b0);
    check32("hold_rst_instr", instr, 32'h0);
    check32("hold_rst_pc", instr_pc, 32'h0);
    tick();
    rst_n = 1'b1;
    fetch_word("restart", 32'h0, 32'h2800_0000, 1);
    consume("restart");
    check32("restart_next", imem_addr, 32'h4);
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst_n       = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = 32'h0;
    instr_ready = 1'b0;
    jump_en     = 1'b0;
    jump_target = 32'h0;
    test_reset();
    test_basic();
    test_stall();
    test_jump_stale();
    test_halt();
    test_wrap();
    test_reset_in_hold();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
